uart_word_loopback: RTL and testbench

UART_WORD_LOOPBACK -- requirements
Module: uart_word_loopback

---
 rtl/uart_word_loopback.sv | 165 ++++++++++++++++
 tb/tb_uart_word_loopback.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_loopback.sv
// Byte-stream loopback: assembles RX characters into words, transforms them per Mode,
// queues them in a word FIFO and serializes them back out LS byte first.
module uart_word_loopback #(
   parameter int ByteWidth = 8,
   parameter int Bytes     = 4,
   parameter int Depth     = 8
) (
   input  logic                       Clock,
   input  logic                       Reset,
   input  logic [1:0]                 Mode,
   input  logic [ByteWidth-1:0]       RXData,
   input  logic                       RXValid,
   output logic                       RXReady,
   output logic [ByteWidth-1:0]       TXData,
   output logic                       TXValid,
   input  logic                       TXReady,
   output logic [Bytes*ByteWidth-1:0] LastWord,
   output logic [15:0]                WordCount,
   output logic                       Overflow
);

   localparam int W  = Bytes * ByteWidth;
   localparam int AW = $clog2(Depth);
   localparam int CW = (Bytes > 1) ? $clog2(Bytes) : 1;
   localparam logic [CW-1:0] LastIdx = CW'(Bytes - 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;

   logic          r_rx_ready;
   logic [CW-1:0] r_byte_cnt;
   logic [W-1:0]  r_asm;
   logic [W-1:0]  r_last_word;
   logic [15:0]   r_word_count;
   logic          r_overflow;

   logic [W-1:0]  r_mem [Depth];
   logic [AW:0]   r_wr_ptr;
   logic [AW:0]   r_rd_ptr;

   logic [0:0]    r_state;
   logic [W-1:0]  r_shift;
   logic [CW-1:0] r_idx;

   logic          w_rx_fire;
   logic          w_complete;
   logic [W-1:0]  w_word;
   logic [W-1:0]  w_xform;
   logic          w_store;
   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic          w_tx_fire;
   logic [W-1:0]  w_head;

   assign w_rx_fire  = RXValid && r_rx_ready;
   assign w_complete = w_rx_fire && (r_byte_cnt == LastIdx);

   // Word as it will look once the byte arriving this cycle is merged in.
   always_comb begin
      w_word = r_asm;
      w_word[int'(r_byte_cnt) * ByteWidth +: ByteWidth] = RXData;
   end

   always_comb begin
      case (Mode)
         2'b01:   w_xform = ~w_word;
         2'b10:   w_xform = w_word + W'(1);
         default: w_xform = w_word;
      endcase
   end

   assign w_store = w_complete && (Mode != 2'b11);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_push  = w_store && (!w_full || w_pop);
   assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

   assign w_tx_fire = (r_state == SEND) && TXReady;
   assign w_pop     = !w_empty && ((r_state == IDLE) || (w_tx_fire && (r_idx == LastIdx)));

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_rx_ready   <= 1'b0;
         r_byte_cnt   <= '0;
         r_asm        <= '0;
         r_last_word  <= '0;
         r_word_count <= '0;
         r_overflow   <= 1'b0;
      end else begin
         r_rx_ready <= 1'b1;
         if (w_rx_fire) begin
            if (w_complete) begin
               r_byte_cnt   <= '0;
               r_asm        <= '0;
               r_last_word  <= w_word;
               r_word_count <= r_word_count + 16'd1;
            end else begin
               r_byte_cnt <= r_byte_cnt + CW'(1);
               r_asm      <= w_word;
            end
         end
         if (w_store && !w_push)
            r_overflow <= 1'b1;
      end
   end

   always_ff @(posedge Clock) begin
      if (w_push)
         r_mem[r_wr_ptr[AW-1:0]] <= w_xform;
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   // The last byte of a word reloads straight from the FIFO so words go out back-to-back.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_state <= IDLE;
         r_shift <= '0;
         r_idx   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_pop) begin
                  r_shift <= w_head;
                  r_idx   <= '0;
                  r_state <= SEND;
               end
            end
            default: begin
               if (w_tx_fire) begin
                  if (r_idx == LastIdx) begin
                     if (w_pop) begin
                        r_shift <= w_head;
                        r_idx   <= '0;
                     end else begin
                        r_state <= IDLE;
                     end
                  end else begin
                     r_shift <= r_shift >> ByteWidth;
                     r_idx   <= r_idx + CW'(1);
                  end
               end
            end
         endcase
      end
   end

   assign RXReady   = r_rx_ready;
   assign TXValid   = (r_state == SEND);
   assign TXData    = r_shift[ByteWidth-1:0];
   assign LastWord  = r_last_word;
   assign WordCount = r_word_count;
   assign Overflow  = r_overflow;

endmodule

// File: tb/tb_uart_word_loopback.sv
// Self-checking bench for uart_word_loopback with default parameters (8-bit bytes, 4-byte words, depth 8).
module tb_uart_word_loopback;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic [1:0]  Mode = 2'b00;
   logic [7:0]  RXData = 8'h00;
   logic        RXValid = 1'b0;
   logic        RXReady;
   logic [7:0]  TXData;
   logic        TXValid;
   logic        TXReady = 1'b1;
   logic [31:0] LastWord;
   logic [15:0] WordCount;
   logic        Overflow;

   uart_word_loopback #(.ByteWidth(8), .Bytes(4), .Depth(8)) dut (
      .Clock(Clock), .Reset(Reset), .Mode(Mode),
      .RXData(RXData), .RXValid(RXValid), .RXReady(RXReady),
      .TXData(TXData), .TXValid(TXValid), .TXReady(TXReady),
      .LastWord(LastWord), .WordCount(WordCount), .Overflow(Overflow)
   );

   always #5 Clock = ~Clock;

   int          total = 0;
   int          bad = 0;
   logic [7:0]  tx_seen[$];
   int          rdy_mode = 0;
   int unsigned cyc = 0;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // TX monitor: records accepted bytes and checks hold-stability under backpressure.
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data = 8'h00;
   always @(negedge Clock) begin
      if (Reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", 64'(TXValid), 64'd1);
            check("stall_data", 64'(TXData), 64'(prev_data));
         end
         if (TXValid && TXReady) tx_seen.push_back(TXData);
         prev_stall = TXValid && !TXReady;
         prev_data  = TXData;
      end
   end

   always @(posedge Clock) begin
      #2;
      case (rdy_mode)
         1: TXReady = 1'($urandom_range(0, 1));
         2: TXReady = (cyc % 3 == 0);
         default: ;
      endcase
      cyc++;
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      RXValid = 1'b0;
      tick();
      tick();
      Reset = 1'b0;
      tick();
   endtask

   task automatic send_byte(input logic [7:0] b);
      RXValid = 1'b1;
      RXData = b;
      tick();
      RXValid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
   endtask

   task automatic wait_bytes(input int n, input int budget);
      int c = 0;
      while (tx_seen.size() < n && c < budget) begin
         tick();
         c++;
      end
   endtask

   function automatic logic [31:0] pop_word();
      logic [31:0] w = '0;
      for (int i = 0; i < 4; i++)
         if (tx_seen.size() > 0) w[8*i +: 8] = tx_seen.pop_front();
      return w;
   endfunction

   function automatic logic [31:0] model_xform(input logic [1:0] m, input logic [31:0] w);
      case (m)
         2'b01:   return ~w;
         2'b10:   return w + 32'd1;
         default: return w;
      endcase
   endfunction

   task automatic check_zero_outputs(input string tag);
      check({tag, "_rxready"}, 64'(RXReady), 64'd0);
      check({tag, "_txvalid"}, 64'(TXValid), 64'd0);
      check({tag, "_txdata"}, 64'(TXData), 64'd0);
      check({tag, "_lastword"}, 64'(LastWord), 64'd0);
      check({tag, "_wordcount"}, 64'(WordCount), 64'd0);
      check({tag, "_overflow"}, 64'(Overflow), 64'd0);
   endtask

   typedef struct {
      logic [1:0]  mode;
      logic [31:0] word;
      logic [31:0] exp_tx;
      bit          exp_send;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic [15:0] exp_wc;
      logic [31:0] exp_last;
      logic [7:0]  exp_q[$];
      logic [31:0] got;

      vecs[0] = '{2'b00, 32'h44332211, 32'h44332211, 1'b1};
      vecs[1] = '{2'b10, 32'hFFFFFFFF, 32'h00000000, 1'b1};
      vecs[2] = '{2'b01, 32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1};
      vecs[3] = '{2'b11, 32'hFFFFFFFF, 32'h00000000, 1'b0};
      vecs[4] = '{2'b10, 32'h000000FF, 32'h00000100, 1'b1};
      vecs[5] = '{2'b01, 32'h00000000, 32'hFFFFFFFF, 1'b1};

      #1;
      check_zero_outputs("reset");
      do_reset();
      check("post_reset_rxready", 64'(RXReady), 64'd1);

      // Echo with latency check.
      Mode = 2'b00;
      TXReady = 1'b1;
      tx_seen.delete();
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      RXValid = 1'b1;
      RXData = 8'h44;
      tick();
      RXValid = 1'b0;
      check("lat_after_complete", 64'(TXValid), 64'd0);
      tick();
      check("lat_second_edge", 64'(TXValid), 64'd1);
      repeat (8) tick();
      check("echo_lastword", 64'(LastWord), 64'h44332211);
      check("echo_wordcount", 64'(WordCount), 64'd1);
      check("echo_count", 64'(tx_seen.size()), 64'd4);
      got = pop_word();
      check("echo_tx", 64'(got), 64'h44332211);

      // Table-driven transforms.
      do_reset();
      exp_wc = 16'd0;
      for (int i = 0; i < 6; i++) begin
         Mode = vecs[i].mode;
         tx_seen.delete();
         send_word(vecs[i].word);
         exp_wc++;
         repeat (15) tick();
         check("vec_lastword", 64'(LastWord), 64'(vecs[i].word));
         check("vec_wordcount", 64'(WordCount), 64'(exp_wc));
         check("vec_count", 64'(tx_seen.size()), vecs[i].exp_send ? 64'd4 : 64'd0);
         if (vecs[i].exp_send) begin
            got = pop_word();
            check("vec_tx", 64'(got), 64'(vecs[i].exp_tx));
         end
      end
      check("vec_overflow", 64'(Overflow), 64'd0);

      // Randomized words, modes, RX gaps and TX readiness against a queue model.
      do_reset();
      tx_seen.delete();
      exp_q.delete();
      exp_wc = 16'd0;
      exp_last = 32'd0;
      rdy_mode = 1;
      for (int n = 0; n < 6; n++) begin
         logic [1:0]  m;
         logic [31:0] w;
         logic [31:0] t;
         m = 2'($urandom_range(0, 3));
         w = $urandom;
         Mode = m;
         for (int b = 0; b < 4; b++) begin
            repeat ($urandom_range(0, 2)) tick();
            send_byte(w[8*b +: 8]);
         end
         exp_wc++;
         exp_last = w;
         if (m != 2'b11) begin
            t = model_xform(m, w);
            for (int b = 0; b < 4; b++) exp_q.push_back(t[8*b +: 8]);
         end
      end
      wait_bytes(exp_q.size(), 400);
      rdy_mode = 0;
      TXReady = 1'b1;
      repeat (10) tick();
      check("rand_count", 64'(tx_seen.size()), 64'(exp_q.size()));
      while (exp_q.size() > 0 && tx_seen.size() > 0)
         check("rand_byte", 64'(tx_seen.pop_front()), 64'(exp_q.pop_front()));
      check("rand_lastword", 64'(LastWord), 64'(exp_last));
      check("rand_wordcount", 64'(WordCount), 64'(exp_wc));
      check("rand_overflow", 64'(Overflow), 64'd0);

      // Backpressure: ready one cycle in three.
      do_reset();
      Mode = 2'b00;
      tx_seen.delete();
      rdy_mode = 2;
      send_word(32'h0C0B0A09);
      send_word(32'h14131211);
      wait_bytes(8, 200);
      rdy_mode = 0;
      TXReady = 1'b1;
      repeat (3) tick();
      check("bp_count", 64'(tx_seen.size()), 64'd8);
      got = pop_word();
      check("bp_word0", 64'(got), 64'h0C0B0A09);
      got = pop_word();
      check("bp_word1", 64'(got), 64'h14131211);

      // Overflow: shift register plus 8 FIFO entries hold 9 words, the 10th is dropped.
      do_reset();
      Mode = 2'b00;
      TXReady = 1'b0;
      tx_seen.delete();
      for (int k = 0; k < 9; k++) send_word(32'hA0B0C0D0 + 32'(k));
      tick();
      check("ovf_not_yet", 64'(Overflow), 64'd0);
      send_word(32'hA0B0C0D9);
      tick();
      check("ovf_flag", 64'(Overflow), 64'd1);
      check("ovf_wordcount", 64'(WordCount), 64'd10);
      check("ovf_lastword", 64'(LastWord), 64'hA0B0C0D9);
      check("ovf_hold_valid", 64'(TXValid), 64'd1);
      check("ovf_hold_data", 64'(TXData), 64'hD0);
      TXReady = 1'b1;
      wait_bytes(36, 300);
      repeat (10) tick();
      check("ovf_count", 64'(tx_seen.size()), 64'd36);
      for (int k = 0; k < 9; k++) begin
         got = pop_word();
         check("ovf_word", 64'(got), 64'(32'hA0B0C0D0 + 32'(k)));
      end
      check("ovf_sticky", 64'(Overflow), 64'd1);

      // Reset mid-word discards the partial word.
      do_reset();
      Mode = 2'b00;
      send_word(32'h0D0C0B0A);
      send_byte(8'h55);
      send_byte(8'h66);
      Reset = 1'b1;
      #1;
      check_zero_outputs("midword");
      tick();
      Reset = 1'b0;
      tick();
      send_word(32'hA4A3A2A1);
      tick();
      check("fresh_lastword", 64'(LastWord), 64'hA4A3A2A1);
      check("fresh_wordcount", 64'(WordCount), 64'd1);

      // Reset mid-SEND aborts the word being transmitted.
      do_reset();
      TXReady = 1'b0;
      tx_seen.delete();
      send_word(32'h78563412);
      repeat (3) tick();
      check("midsend_valid_before", 64'(TXValid), 64'd1);
      Reset = 1'b1;
      #1;
      check_zero_outputs("midsend");
      tick();
      Reset = 1'b0;
      TXReady = 1'b1;
      repeat (10) tick();
      check("midsend_no_tx", 64'(tx_seen.size()), 64'd0);
      check("midsend_idle", 64'(TXValid), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
